// File: rtl/mem_bank_ctrl.sv
// Ping-pong frame bank controller: tracks write/read bank roles, swap pulses and frame drop/repeat statistics.
// Optional statistics counters are enabled with macro MEM_BANK_CTRL_STATS_EN (default build: counters read 0).
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_EMPTY | no complete frame yet; reader must not consume, rd_done ignored
// ST_RUN   | read bank holds a complete frame; pending marks an unread one
//          | sitting in the write bank
module mem_bank_ctrl #(
    parameter int FRAME_DEPTH = 16384,
    parameter int ADDR_WIDTH  = 15
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_wr_done,
    input  logic                  i_rd_done,
    output logic [ADDR_WIDTH-1:0] o_wr_base,
    output logic [ADDR_WIDTH-1:0] o_rd_base,
    output logic                  o_rd_valid,
    output logic                  o_swap,
    output logic [15:0]           o_drop_cnt,
    output logic [15:0]           o_repeat_cnt
);

    localparam logic [ADDR_WIDTH-1:0] BANK1_BASE = ADDR_WIDTH'(FRAME_DEPTH);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                state_q;
    logic                  pending_q;
    logic                  wr_bank_q;
    logic                  rd_bank_q;
    logic                  rd_valid_q;
    logic                  swap_q;
    logic [ADDR_WIDTH-1:0] wr_base_q;
    logic [ADDR_WIDTH-1:0] rd_base_q;
    logic                  do_swap;

    function automatic logic [ADDR_WIDTH-1:0] base_of(input logic bank);
        return bank ? BANK1_BASE : '0;
    endfunction

    // A simultaneous write-done hands the fresh frame straight to the reader,
    // so it swaps whatever the pending flag says.
    assign do_swap = (state_q == ST_RUN) && i_rd_done && (i_wr_done || pending_q);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= ST_EMPTY;
            pending_q  <= 1'b0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            swap_q     <= 1'b0;
            wr_base_q  <= '0;
            rd_base_q  <= '0;
        end else begin
            swap_q <= 1'b0;
            case (state_q)
                ST_EMPTY: begin
                    if (i_wr_done) begin
                        rd_bank_q  <= 1'b0;
                        wr_bank_q  <= 1'b1;
                        rd_base_q  <= base_of(1'b0);
                        wr_base_q  <= base_of(1'b1);
                        rd_valid_q <= 1'b1;
                        swap_q     <= 1'b1;
                        pending_q  <= 1'b0;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (do_swap) begin
                        rd_bank_q <= wr_bank_q;
                        wr_bank_q <= rd_bank_q;
                        rd_base_q <= base_of(wr_bank_q);
                        wr_base_q <= base_of(rd_bank_q);
                        pending_q <= 1'b0;
                        swap_q    <= 1'b1;
                    end else if (i_wr_done) begin
                        pending_q <= 1'b1;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    assign o_wr_base  = wr_base_q;
    assign o_rd_base  = rd_base_q;
    assign o_rd_valid = rd_valid_q;
    assign o_swap     = swap_q;

`ifdef MEM_BANK_CTRL_STATS_EN
    logic        drop_evt;
    logic        repeat_evt;
    logic [15:0] drop_cnt_q;
    logic [15:0] drop_cnt_d;
    logic [15:0] repeat_cnt_q;
    logic [15:0] repeat_cnt_d;

    // Drop: writer finished again while the previous frame was still unread.
    // Repeat: reader finished with nothing new, so it re-reads the same bank.
    assign drop_evt   = (state_q == ST_RUN) && i_wr_done && !i_rd_done && pending_q;
    assign repeat_evt = (state_q == ST_RUN) && i_rd_done && !i_wr_done && !pending_q;

    always_comb begin
        drop_cnt_d   = drop_cnt_q;
        repeat_cnt_d = repeat_cnt_q;
        if (drop_evt && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        if (repeat_evt && (repeat_cnt_q != 16'hFFFF)) begin
            repeat_cnt_d = repeat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            drop_cnt_q   <= 16'h0000;
            repeat_cnt_q <= 16'h0000;
        end else begin
            drop_cnt_q   <= drop_cnt_d;
            repeat_cnt_q <= repeat_cnt_d;
        end
    end

    assign o_drop_cnt   = drop_cnt_q;
    assign o_repeat_cnt = repeat_cnt_q;
`else
    assign o_drop_cnt   = 16'h0000;
    assign o_repeat_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Self-checking bench for mem_bank_ctrl: directed scenarios plus randomized traffic against a frame-level model.
module tb_mem_bank_ctrl;

    localparam int FD = 16384;
    localparam int AW = 15;
`ifdef MEM_BANK_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rstn = 1'b0;
    logic          i_wr_done = 1'b0;
    logic          i_rd_done = 1'b0;
    logic [AW-1:0] o_wr_base;
    logic [AW-1:0] o_rd_base;
    logic          o_rd_valid;
    logic          o_swap;
    logic [15:0]   o_drop_cnt;
    logic [15:0]   o_repeat_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame-level model: which physical bank each side owns, plus frame counts.
    bit m_run, m_pend, m_swap;
    int m_rdb, m_wrb, m_drop, m_rep;

    mem_bank_ctrl #(.FRAME_DEPTH(FD), .ADDR_WIDTH(AW)) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_wr_done   (i_wr_done),
        .i_rd_done   (i_rd_done),
        .o_wr_base   (o_wr_base),
        .o_rd_base   (o_rd_base),
        .o_rd_valid  (o_rd_valid),
        .o_swap      (o_swap),
        .o_drop_cnt  (o_drop_cnt),
        .o_repeat_cnt(o_repeat_cnt)
    );

    always #4 i_clk = ~i_clk;

    initial begin
        #5ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        m_run = 0; m_pend = 0; m_swap = 0;
        m_rdb = 0; m_wrb = 0; m_drop = 0; m_rep = 0;
    endfunction

    function automatic void model_step(bit wr, bit rd);
        int t;
        m_swap = 0;
        if (!m_run) begin
            if (wr) begin
                m_run = 1; m_rdb = 0; m_wrb = 1; m_swap = 1; m_pend = 0;
            end
        end else if (rd && (wr || m_pend)) begin
            t = m_rdb; m_rdb = m_wrb; m_wrb = t;
            m_pend = 0; m_swap = 1;
        end else if (wr) begin
            if (m_pend && m_drop < 65535) m_drop++;
            m_pend = 1;
        end else if (rd) begin
            if (m_rep < 65535) m_rep++;
        end
    endfunction

    function automatic logic [AW-1:0] exp_base(int bank);
        return AW'(bank * FD);
    endfunction

    function automatic logic [15:0] exp_cnt(int v);
        return STATS ? 16'(v) : 16'h0000;
    endfunction

    // Called at posedge+1; inputs are sampled on the next edge, outputs checked 1 time unit after it.
    task automatic step(input bit wr, input bit rd);
        i_wr_done = wr;
        i_rd_done = rd;
        @(posedge i_clk);
        model_step(wr, rd);
        #1;
        i_wr_done = 1'b0;
        i_rd_done = 1'b0;
    endtask

    task automatic do_reset();
        i_rstn = 1'b0;
        i_wr_done = 1'b0;
        i_rd_done = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        model_reset();
        i_rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (o_wr_base !== '0) begin n_fail++; $display("FAIL reset_wr_base got %0d want 0", o_wr_base); end
        n_checks++; if (o_rd_base !== '0) begin n_fail++; $display("FAIL reset_rd_base got %0d want 0", o_rd_base); end
        n_checks++; if (o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", o_rd_valid); end
        n_checks++; if (o_swap !== 1'b0) begin n_fail++; $display("FAIL reset_swap got %b want 0", o_swap); end
        n_checks++; if (o_drop_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_drop got %0d want 0", o_drop_cnt); end
        n_checks++; if (o_repeat_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_repeat got %0d want 0", o_repeat_cnt); end
        step(0, 1);
        n_checks++; if (o_rd_valid !== 1'b0 || o_swap !== 1'b0) begin n_fail++; $display("FAIL empty_rd_ignored got valid=%b swap=%b want 0/0", o_rd_valid, o_swap); end
        n_checks++; if (o_repeat_cnt !== 16'h0) begin n_fail++; $display("FAIL empty_rd_no_repeat got %0d want 0", o_repeat_cnt); end
    endtask

    task automatic test_first_frame();
        step(1, 0);
        n_checks++; if (o_rd_base !== 15'd0) begin n_fail++; $display("FAIL first_rd_base got %0d want 0", o_rd_base); end
        n_checks++; if (o_wr_base !== 15'd16384) begin n_fail++; $display("FAIL first_wr_base got %0d want 16384", o_wr_base); end
        n_checks++; if (o_rd_valid !== 1'b1) begin n_fail++; $display("FAIL first_rd_valid got %b want 1", o_rd_valid); end
        n_checks++; if (o_swap !== 1'b1) begin n_fail++; $display("FAIL first_swap got %b want 1", o_swap); end
        step(0, 0);
        n_checks++; if (o_swap !== 1'b0) begin n_fail++; $display("FAIL first_swap_width got %b want 0", o_swap); end
    endtask

    task automatic test_swap();
        step(1, 0);
        n_checks++; if (o_swap !== 1'b0) begin n_fail++; $display("FAIL pend_no_swap got %b want 0", o_swap); end
        step(0, 0);
        step(0, 1);
        n_checks++; if (o_rd_base !== 15'd16384) begin n_fail++; $display("FAIL swap_rd_base got %0d want 16384", o_rd_base); end
        n_checks++; if (o_wr_base !== 15'd0) begin n_fail++; $display("FAIL swap_wr_base got %0d want 0", o_wr_base); end
        n_checks++; if (o_swap !== 1'b1) begin n_fail++; $display("FAIL swap_pulse got %b want 1", o_swap); end
        n_checks++; if (o_drop_cnt !== 16'h0 || o_repeat_cnt !== 16'h0) begin n_fail++; $display("FAIL swap_counters got %0d/%0d want 0/0", o_drop_cnt, o_repeat_cnt); end
    endtask

    task automatic test_repeat();
        for (int i = 0; i < 3; i++) begin
            step(0, 1);
            n_checks++; if (o_swap !== 1'b0) begin n_fail++; $display("FAIL repeat_no_swap[%0d] got %b want 0", i, o_swap); end
        end
        n_checks++; if (o_repeat_cnt !== exp_cnt(3)) begin n_fail++; $display("FAIL repeat_cnt got %0d want %0d", o_repeat_cnt, exp_cnt(3)); end
        n_checks++; if (o_rd_base !== 15'd16384 || o_wr_base !== 15'd0) begin n_fail++; $display("FAIL repeat_bases got rd=%0d wr=%0d want 16384/0", o_rd_base, o_wr_base); end
    endtask

    task automatic test_drop_and_simul();
        step(1, 0);
        step(1, 0);
        n_checks++; if (o_drop_cnt !== exp_cnt(1)) begin n_fail++; $display("FAIL drop_cnt got %0d want %0d", o_drop_cnt, exp_cnt(1)); end
        step(1, 1);
        n_checks++; if (o_swap !== 1'b1) begin n_fail++; $display("FAIL simul_swap got %b want 1", o_swap); end
        n_checks++; if (o_rd_base !== 15'd0 || o_wr_base !== 15'd16384) begin n_fail++; $display("FAIL simul_bases got rd=%0d wr=%0d want 0/16384", o_rd_base, o_wr_base); end
        n_checks++; if (o_drop_cnt !== exp_cnt(1) || o_repeat_cnt !== exp_cnt(3)) begin n_fail++; $display("FAIL simul_counters got %0d/%0d want %0d/%0d", o_drop_cnt, o_repeat_cnt, exp_cnt(1), exp_cnt(3)); end
        // Pending must now be clear: a lone rd_done repeats instead of swapping.
        step(0, 1);
        n_checks++; if (o_swap !== 1'b0 || o_repeat_cnt !== exp_cnt(4)) begin n_fail++; $display("FAIL simul_pend_clear got swap=%b rep=%0d want 0/%0d", o_swap, o_repeat_cnt, exp_cnt(4)); end
    endtask

    task automatic test_async_reset();
        step(1, 0);
        #2;
        i_rstn = 1'b0;
        #1;
        n_checks++;
        if (o_wr_base !== '0 || o_rd_base !== '0 || o_rd_valid !== 1'b0 || o_swap !== 1'b0 ||
            o_drop_cnt !== 16'h0 || o_repeat_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset got wr=%0d rd=%0d v=%b s=%b d=%0d r=%0d want all 0",
                     o_wr_base, o_rd_base, o_rd_valid, o_swap, o_drop_cnt, o_repeat_cnt);
        end
        @(posedge i_clk);
        #1;
        model_reset();
        i_rstn = 1'b1;
        step(0, 1);
        n_checks++; if (o_rd_valid !== 1'b0 || o_swap !== 1'b0 || o_repeat_cnt !== 16'h0) begin n_fail++; $display("FAIL post_reset_rd got v=%b s=%b r=%0d want 0/0/0", o_rd_valid, o_swap, o_repeat_cnt); end
    endtask

    task automatic test_random();
        bit wr, rd;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            wr = ($urandom_range(0, 99) < 40);
            rd = ($urandom_range(0, 99) < 40);
            step(wr, rd);
            n_checks++;
            if (o_rd_base !== exp_base(m_rdb) || o_wr_base !== exp_base(m_wrb) ||
                o_rd_valid !== m_run || o_swap !== m_swap ||
                o_drop_cnt !== exp_cnt(m_drop) || o_repeat_cnt !== exp_cnt(m_rep)) begin
                n_fail++;
                $display("FAIL rand[%0d] got rd=%0d wr=%0d v=%b s=%b d=%0d r=%0d want rd=%0d wr=%0d v=%b s=%b d=%0d r=%0d",
                         i, o_rd_base, o_wr_base, o_rd_valid, o_swap, o_drop_cnt, o_repeat_cnt,
                         exp_base(m_rdb), exp_base(m_wrb), m_run, m_swap, exp_cnt(m_drop), exp_cnt(m_rep));
            end
            if (m_run) begin
                n_checks++;
                if (o_rd_base === o_wr_base) begin n_fail++; $display("FAIL rand_bases_distinct[%0d] got %0d want differing", i, o_rd_base); end
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        step(1, 0);
        for (int i = 0; i < 65534; i++) step(0, 1);
        n_checks++; if (o_repeat_cnt !== exp_cnt(16'hFFFE)) begin n_fail++; $display("FAIL sat_pre got %h want %h", o_repeat_cnt, exp_cnt(16'hFFFE)); end
        for (int i = 0; i < 3; i++) begin
            step(0, 1);
            n_checks++; if (o_repeat_cnt !== exp_cnt(16'hFFFF)) begin n_fail++; $display("FAIL sat_hold[%0d] got %h want %h", i, o_repeat_cnt, exp_cnt(16'hFFFF)); end
        end
        n_checks++; if (o_rd_base !== 15'd0 || o_swap !== 1'b0) begin n_fail++; $display("FAIL sat_bases got rd=%0d s=%b want 0/0", o_rd_base, o_swap); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_frame();
        test_swap();
        test_repeat();
        test_drop_and_simul();
        test_async_reset();
        test_random();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bank_ctrl.md
MEM_BANK_CTRL -- requirements
Module: mem_bank_ctrl

Interface
REQ-001 SHALL have parameter FRAME_DEPTH, default 16384: BRAM words per frame bank.
REQ-002 SHALL have parameter ADDR_WIDTH, default 15: BRAM address width; must satisfy 2*FRAME_DEPTH <= 2^ADDR_WIDTH.
REQ-003 SHALL have port i_clk, input, 1: single 125 MHz clock; all logic on its rising edge.
REQ-004 SHALL have port i_rstn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port i_wr_done, input, 1: one-cycle pulse; the writer has finished writing one frame into the current write bank.
REQ-006 SHALL have port i_rd_done, input, 1: one-cycle pulse; the reader has finished reading one frame from the current read bank.
REQ-007 SHALL have port o_wr_base, output, ADDR_WIDTH: base address of the write bank.
REQ-008 SHALL have port o_rd_base, output, ADDR_WIDTH: base address of the read bank.
REQ-009 SHALL have port o_rd_valid, output, 1: the read bank holds a complete frame.
REQ-010 SHALL have port o_swap, output, 1: one-cycle pulse when the banks exchange roles.
REQ-011 SHALL have port o_drop_cnt, output, 16: count of frames dropped.
REQ-012 SHALL have port o_repeat_cnt, output, 16: count of frames repeated.

Function
REQ-013 SHALL derive each base as bank index * FRAME_DEPTH, with bank 0 -> 0 and bank 1 -> FRAME_DEPTH; all outputs SHALL be registered.
REQ-014 SHALL implement FSM states EMPTY and RUN, plus a 1-bit pending flag (the write bank holds a completed, unread frame).
REQ-015 In EMPTY, i_wr_done SHALL cause the following on the next edge:
  - rd bank <= 0, wr bank <= 1;
  - o_rd_valid <= 1, o_swap pulses;
  - state -> RUN.
REQ-016 In EMPTY, i_rd_done SHALL be ignored, with no counter change.
REQ-017 In RUN, i_wr_done alone with pending=0 SHALL set pending=1.
REQ-018 In RUN, i_wr_done alone with pending=1 SHALL keep pending=1 and increment o_drop_cnt; the writer then overwrites the same bank.
REQ-019 In RUN, i_rd_done alone with pending=1 SHALL swap the banks, clear pending and pulse o_swap.
REQ-020 In RUN, i_rd_done alone with pending=0 SHALL keep the banks unchanged and increment o_repeat_cnt.
REQ-021 In RUN, i_wr_done and i_rd_done in the same cycle SHALL swap the banks, clear pending and pulse o_swap, with no drop and no repeat, regardless of the prior pending value.
REQ-022 o_wr_base and o_rd_base SHALL never be equal while in RUN.
REQ-023 Bank, valid and swap outputs SHALL reflect an event exactly 1 cycle after the input pulse.
REQ-024 Counters SHALL saturate at 16'hFFFF and never wrap.
REQ-025 RUN SHALL never return to EMPTY except through reset.

Reset
REQ-026 i_rstn low SHALL immediately and asynchronously force the following, including mid-frame:
  - state EMPTY, pending 0;
  - wr bank 0, rd bank 0;
  - o_rd_valid 0, o_swap 0;
  - both counters 0.
REQ-027 Deassertion SHALL be synchronous to i_clk; the first event is accepted on the first edge with i_rstn high.

Configuration
REQ-028 With macro MEM_BANK_CTRL_STATS_EN defined, o_drop_cnt and o_repeat_cnt SHALL be implemented per REQ-018, REQ-020 and REQ-024.
REQ-029 Without MEM_BANK_CTRL_STATS_EN, o_drop_cnt and o_repeat_cnt SHALL be constant 0, with no counter registers.
REQ-030 Bank sequencing SHALL be identical with and without MEM_BANK_CTRL_STATS_EN.

Verification (FRAME_DEPTH=16384, ADDR_WIDTH=15, MEM_BANK_CTRL_STATS_EN defined)
REQ-031 Reset, then i_wr_done -> next cycle: o_rd_base=0, o_wr_base=16384, o_rd_valid=1, o_swap=1 for exactly 1 cycle.
REQ-032 In RUN: i_wr_done, then later i_rd_done -> o_rd_base=16384, o_wr_base=0, o_swap pulses, counters unchanged.
REQ-033 In RUN with pending=0, three i_rd_done pulses -> o_repeat_cnt=3, bases unchanged, no o_swap.
REQ-034 In RUN, two i_wr_done with no i_rd_done -> o_drop_cnt=1; then i_wr_done and i_rd_done in the same cycle -> swap, o_drop_cnt stays 1, pending=0.
REQ-035 o_repeat_cnt forced to 16'hFFFE by 3 extra repeats -> reads 16'hFFFF and holds.
REQ-036 i_rstn asserted mid-RUN between clock edges -> all outputs 0 before the next edge; then i_rd_done -> ignored, o_rd_valid=0.
